// File: rtl/axi_rd_slave_ram_if.sv
// axi_rd_slave_ram_if: AXI3 read address and read data channel bundle
interface axi_rd_slave_ram_if;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [1:0] arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic arvalid;
  logic arready;
  logic [3:0] rid;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_slave_ram.sv
// axi_rd_slave_ram: AXI3 read-channel responder backed by a backdoor-loaded word RAM
module axi_rd_slave_ram #(
  parameter int ADDR_W = 10,
  parameter int READ_LAT = 2,
  parameter int OUTSTANDING = 2
) (
  input logic clk,
  input logic reset,
  axi_rd_slave_ram_if.slave bus,
  input logic mem_we,
  input logic [ADDR_W-1:0] mem_waddr,
  input logic [31:0] mem_wdata
);
  localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  typedef struct packed {
    logic [3:0] id;
    logic [31:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } req_t;
  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
  logic [31:0] mem [2**ADDR_W];
  req_t q [OUTSTANDING];
  req_t head;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  state_t state, state_nx;
  logic [15:0] cnt;
  logic [3:0] id;
  logic [31:0] addr;
  logic [7:0] left;
  logic [2:0] size;
  logic [1:0] burst;
  logic err;
  logic push, pop, load, done, full, empty;
  logic [3:0] ld_id;
  logic [31:0] ld_addr, ld_next;
  logic [7:0] ld_left;
  logic [2:0] ld_size;
  logic ld_fixed, ld_err;
  logic [3:0] r_id;
  logic [31:0] r_data;
  logic [1:0] r_resp;
  logic r_last, r_valid;
  logic unused_ok;
  assign full = count == CW'(OUTSTANDING);
  assign empty = count == '0;
  assign head = q[rptr];
  assign bus.arready = !full && !reset;
  assign push = bus.arvalid && bus.arready;
  assign bus.rid = r_id;
  assign bus.rdata = r_data;
  assign bus.rresp = r_resp;
  assign bus.rlast = r_last;
  assign bus.rvalid = r_valid;
  assign unused_ok = ^{bus.arlock, bus.arcache, bus.arprot};
  // backdoor RAM load port; contents survive reset
  always_ff @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  // request queue: push on AR handshake, pop when the engine picks up the head
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q[wptr] <= {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst};
        wptr <= wptr == PW'(OUTSTANDING - 1) ? '0 : wptr + 1'b1;
      end
      if (pop) rptr <= rptr == PW'(OUTSTANDING - 1) ? '0 : rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  // next state: pop when idle, count out the latency, leave after the last beat handshake
  always_comb
    state_nx = state == IDLE ? (empty ? IDLE : READ_LAT == 0 ? BURST : WAIT) :
               state == WAIT ? (cnt == '0 ? BURST : WAIT) :
               done ? IDLE : BURST;
  // control strobes and the source of the beat being loaded (queue head when loading straight from idle)
  always_comb begin
    pop = state == IDLE && !empty;
    done = state == BURST && bus.rready && r_last;
    load = (pop && READ_LAT == 0) || (state == WAIT && cnt == '0) || (state == BURST && bus.rready && !r_last);
    ld_id = state == IDLE ? head.id : id;
    ld_addr = state == IDLE ? head.addr : addr;
    ld_left = state == IDLE ? head.len : left;
    ld_size = state == IDLE ? head.size : size;
    ld_fixed = (state == IDLE ? head.burst : burst) == 2'b00;
    ld_err = state == IDLE ? (head.burst[1] || head.size > 3'd2) : err;
    ld_next = ld_fixed ? ld_addr : ld_addr + (32'd1 << ld_size);
  end
  // burst engine: latch the request on pop, register each beat as it is loaded
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_last <= 1'b0;
      r_id <= '0;
      r_data <= '0;
      r_resp <= '0;
      cnt <= '0;
    end else begin
      if (pop) begin
        id <= head.id;
        size <= head.size;
        burst <= head.burst;
        err <= head.burst[1] || head.size > 3'd2;
        cnt <= 16'(READ_LAT - 1);
      end else if (state == WAIT) cnt <= cnt - 1'b1;
      if (load) begin
        addr <= ld_next;
        left <= ld_left - 1'b1;
        r_id <= ld_id;
        r_data <= ld_err ? '0 : mem[ld_addr[ADDR_W+1:2]];
        r_resp <= ld_err ? 2'b10 : 2'b00;
        r_last <= ld_left == '0;
        r_valid <= 1'b1;
      end else begin
        if (pop) begin
          addr <= head.addr;
          left <= head.len;
        end
        if (done) r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_rd_slave_ram.sv
// tb_axi_rd_slave_ram: directed read bursts checked against a cycle-level behavioural model
module tb_axi_rd_slave_ram;
  localparam int LAT = 2, OUT = 2, AW = 10;
  typedef struct {
    int id;
    logic [31:0] addr;
    int len;
    int size;
    int bst;
    int t;
    int idx;
  } burst_t;
  logic clk = 0, reset = 1, mem_we = 0;
  logic [AW-1:0] mem_waddr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0] pat = 4'b1001;
  logic [31:0] ram [1<<AW];
  burst_t q[$];
  burst_t b;
  int done_ids[$];
  int total = 0, bad = 0, cyc = 0, last_done = -100;
  bit rst_q = 1;
  bit m_popped, m_exp_v, m_err;
  int m_pop_c, m_occ;
  logic [31:0] m_a;
  logic [31:0] cd [16];
  logic [1:0] cr [16];
  logic cl [16];
  logic [3:0] ci [16];
  int cc [16];
  int cn = 0;
  int n_acc;
  axi_rd_slave_ram_if bus();
  axi_rd_slave_ram #(.ADDR_W(AW), .READ_LAT(LAT), .OUTSTANDING(OUT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );
  always #5 clk = ~clk;
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected handshake", nm);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ar(input int id, input logic [31:0] a, input int len, input int sz, input int bst, output int t);
    bit ok = 0;
    t = -1;
    bus.arid = 4'(id);
    bus.araddr = a;
    bus.arlen = 8'(len);
    bus.arsize = 3'(sz);
    bus.arburst = 2'(bst);
    bus.arvalid = 1;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (bus.arready) begin
        ok = 1;
        t = cyc;
      end
    end
    if (!ok) timeout("ar_accept");
    tick();
    bus.arvalid = 0;
  endtask
  task automatic collect(input int n);
    for (int k = 0; k < 400 && cn < n; k++) @(negedge clk);
    if (cn < n) timeout("collect");
    tick();
  endtask
  task automatic drain();
    int k;
    for (k = 0; k < 500 && q.size() > 0; k++) tick();
    if (q.size() > 0) timeout("drain");
  endtask
  always @(posedge clk) begin
    cyc++;
    rst_q = reset;
  end
  // capture of completed beats for the literal checks
  always @(negedge clk) begin
    if (!reset && bus.rvalid && bus.rready && cn < 16) begin
      cd[cn] = bus.rdata;
      cr[cn] = bus.rresp;
      cl[cn] = bus.rlast;
      ci[cn] = bus.rid;
      cc[cn] = cyc;
      cn++;
    end
  end
  // model: a burst accepted at cycle T starts once the previous one is done at L, popped at max(T,L)+2, valid LAT later
  always @(negedge clk) begin
    if (reset) begin
      chk("arready_rst", bus.arready, 0);
      if (rst_q) begin
        chk("rvalid_rst", bus.rvalid, 0);
        chk("rlast_rst", bus.rlast, 0);
        chk("rid_rst", bus.rid, 0);
        chk("rdata_rst", bus.rdata, 0);
        chk("rresp_rst", bus.rresp, 0);
      end
      q.delete();
      last_done = -100;
    end else begin
      m_popped = 0;
      m_exp_v = 0;
      if (q.size() > 0) begin
        m_pop_c = (q[0].t > last_done ? q[0].t : last_done) + 2;
        m_popped = cyc >= m_pop_c;
        m_exp_v = q[0].idx > 0 || cyc >= m_pop_c + LAT;
      end
      m_occ = q.size() - int'(m_popped);
      chk("arready", bus.arready, 32'(m_occ < OUT));
      chk("rvalid", bus.rvalid, 32'(m_exp_v));
      if (m_exp_v && bus.rvalid) begin
        b = q[0];
        m_err = b.bst >= 2 || b.size > 2;
        m_a = b.bst == 0 ? b.addr : b.addr + 32'(b.idx << b.size);
        chk("rid", bus.rid, b.id);
        chk("rdata", bus.rdata, m_err ? 32'h0 : ram[m_a[AW+1:2]]);
        chk("rresp", bus.rresp, m_err ? 2 : 0);
        chk("rlast", bus.rlast, 32'(b.idx == b.len));
        if (bus.rready) begin
          if (b.idx == b.len) begin
            last_done = cyc;
            done_ids.push_back(b.id);
            void'(q.pop_front());
          end else q[0].idx++;
        end
      end
      if (bus.arvalid && bus.arready)
        q.push_back('{int'(bus.arid), bus.araddr, int'(bus.arlen), int'(bus.arsize), int'(bus.arburst), cyc, 0});
    end
  end
  initial begin
    int t, t4, base;
    bus.arvalid = 0;
    bus.arid = 0;
    bus.araddr = 0;
    bus.arlen = 0;
    bus.arsize = 0;
    bus.arburst = 0;
    bus.arlock = 0;
    bus.arcache = 0;
    bus.arprot = 0;
    bus.rready = 1;
    tick();
    for (int i = 0; i < (1 << AW); i++) begin
      mem_we = 1;
      mem_waddr = AW'(i);
      mem_wdata = 32'hA000_0000 + 32'(i);
      ram[i] = mem_wdata;
      tick();
    end
    mem_we = 0;
    reset = 0;
    tick();
    // single beat and first-beat latency
    cn = 0;
    ar(1, 32'h10, 0, 2, 1, t);
    collect(1);
    chk("t1_data", cd[0], 32'hA000_0004);
    chk("t1_id", ci[0], 1);
    chk("t1_resp", cr[0], 0);
    chk("t1_last", cl[0], 1);
    chk("t1_lat", cc[0] - t, 4);
    // INCR back-to-back
    cn = 0;
    ar(2, 32'h20, 3, 2, 1, t);
    collect(4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_data", cd[k], 32'hA000_0008 + 32'(k));
      chk("t2_last", cl[k], 32'(k == 3));
      chk("t2_gap", cc[k] - cc[0], k);
    end
    // stalls with rready 1,0,0,1
    cn = 0;
    fork
      begin
        ar(3, 32'h20, 3, 2, 1, t);
        collect(4);
      end
      for (int i = 0; i < 40; i++) begin
        tick();
        bus.rready = pat[i % 4];
      end
    join
    bus.rready = 1;
    drain();
    for (int k = 0; k < 4; k++) chk("t3_data", cd[k], 32'hA000_0008 + 32'(k));
    chk("t3_count", cn, 4);
    chk("t3_stall", 32'(cc[3] - cc[0] > 3), 1);
    // queue fills while R is stalled
    base = done_ids.size();
    n_acc = 0;
    bus.rready = 0;
    fork
      begin
        ar(4, 32'h00, 1, 2, 1, t4);
        n_acc++;
        ar(5, 32'h40, 0, 2, 1, t4);
        n_acc++;
        ar(6, 32'h80, 2, 2, 1, t4);
        n_acc++;
        ar(7, 32'hC0, 0, 2, 1, t4);
        n_acc++;
      end
      begin
        repeat (15) tick();
        chk("t4_arready", bus.arready, 0);
        chk("t4_accepted", n_acc, 3);
        bus.rready = 1;
      end
    join
    drain();
    chk("t4_n", done_ids.size() - base, 4);
    for (int k = 0; k < 4 && base + k < done_ids.size(); k++) chk("t4_order", done_ids[base + k], 4 + k);
    // unsupported burst type and size, FIXED burst
    cn = 0;
    ar(8, 32'h0, 1, 2, 2, t);
    collect(2);
    for (int k = 0; k < 2; k++) begin
      chk("t5_err_resp", cr[k], 2);
      chk("t5_err_data", cd[k], 0);
      chk("t5_err_last", cl[k], 32'(k == 1));
    end
    cn = 0;
    ar(9, 32'h8, 2, 2, 0, t);
    collect(3);
    for (int k = 0; k < 3; k++) begin
      chk("t5_fixed_data", cd[k], 32'hA000_0002);
      chk("t5_fixed_last", cl[k], 32'(k == 2));
    end
    cn = 0;
    ar(10, 32'h4, 0, 3, 1, t);
    collect(1);
    chk("t5_size_resp", cr[0], 2);
    chk("t5_size_data", cd[0], 0);
    // reset in the middle of a burst
    cn = 0;
    ar(11, 32'h0, 3, 2, 1, t);
    for (int k = 0; k < 100 && !(cn == 1 && bus.rvalid); k++) tick();
    chk("t6_mid", cn, 1);
    bus.rready = 0;
    reset = 1;
    tick();
    chk("t6_rvalid", bus.rvalid, 0);
    chk("t6_arready", bus.arready, 0);
    tick();
    reset = 0;
    bus.rready = 1;
    tick();
    cn = 0;
    ar(12, 32'h10, 0, 2, 1, t);
    collect(1);
    chk("t6_data", cd[0], 32'hA000_0004);
    chk("t6_id", ci[0], 12);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
